// File: rtl/rr_arb_3t1_pkg.sv
// Shared definitions for the three-way round-robin arbiter:
// FSM encodings, mux select constants and small index helpers.
package rr_arb_3t1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [1:0] SEL_IDLE = 2'd3;
    localparam logic [1:0] REQ_IDX0 = 2'd0;
    localparam logic [1:0] REQ_IDX1 = 2'd1;
    localparam logic [1:0] REQ_IDX2 = 2'd2;
    localparam logic [1:0] LAST_RST = REQ_IDX2;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            REQ_IDX0: oh = 3'b001;
            REQ_IDX1: oh = 3'b010;
            REQ_IDX2: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] add_mod3(
        input logic [1:0] a,
        input logic [1:0] b
    );
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    function automatic logic req_at(
        input logic [2:0] req,
        input logic [1:0] idx
    );
        logic r;
        case (idx)
            REQ_IDX0: r = req[0];
            REQ_IDX1: r = req[1];
            REQ_IDX2: r = req[2];
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_3t1_if.sv
// Request/grant bundle between the arbiter and its three requesters
// plus the mux select and resource completion strobe.
interface rr_arb_3t1_if;

    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        input  req,
        input  done,
        output gnt,
        output sel,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout
    );

endinterface

// File: rtl/rr_arb_3t1_pick3.sv
// Combinational round-robin pick: scans LAST+1, LAST+2, LAST
// and returns the first requester found.
module rr_pick3
    import rr_arb_3t1_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] win_o,
    output logic       any_o
);

    logic [1:0] base;
    logic [2:0] rot;
    logic [1:0] off;

    always_comb begin
        case (last_i)
            REQ_IDX0: base = REQ_IDX1;
            REQ_IDX1: base = REQ_IDX2;
            default:  base = REQ_IDX0;
        endcase
    end

    // rot[0] is the highest-priority candidate this cycle
    always_comb begin
        case (base)
            REQ_IDX1: rot = {req_i[0], req_i[2], req_i[1]};
            REQ_IDX2: rot = {req_i[1], req_i[0], req_i[2]};
            default:  rot = req_i;
        endcase
    end

    always_comb begin
        off = 2'd0;
        priority case (1'b1)
            rot[0]:  off = 2'd0;
            rot[1]:  off = 2'd1;
            rot[2]:  off = 2'd2;
            default: off = 2'd0;
        endcase
    end

    assign win_o = add_mod3(base, off);
    assign any_o = |req_i;

endmodule

// File: rtl/rr_arb_3t1.sv
// Round-robin arbiter for three requesters with a bounded hold time
// and a one-cycle break-before-make gap between grants.
module rr_arb_3t1
    import rr_arb_3t1_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    rr_arb_3t1_if.master arb
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_HOLD - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    last_q, last_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          tout_q, tout_d;

    logic [1:0] win;
    logic       any;
    logic       at_lim;
    logic       req_cur;
    logic       rel;

    rr_pick3 u_pick (
        .req_i  (arb.req),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (any)
    );

    assign at_lim  = (cnt_q == CNT_LIM);
    assign req_cur = req_at(arb.req, sel_q);
    assign rel     = arb.done | ~req_cur | at_lim;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            gnt_q   <= 3'b000;
            sel_q   <= SEL_IDLE;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                state_d = any ? ST_GRANT : ST_IDLE;
            end
            ST_GRANT: begin
                state_d = rel ? ST_RELEASE : ST_GRANT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = 3'b000;
        sel_d  = SEL_IDLE;
        busy_d = 1'b0;
        tout_d = 1'b0;
        cnt_d  = cnt_q;
        last_d = last_q;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                cnt_d = '0;
                if (any) begin
                    gnt_d  = onehot3(win);
                    sel_d  = win;
                    busy_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    cnt_d  = '0;
                    last_d = sel_q;
                    // forced release only when nothing else ended it
                    tout_d = at_lim & ~arb.done & req_cur;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    gnt_d  = gnt_q;
                    sel_d  = sel_q;
                    busy_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign arb.gnt     = gnt_q;
    assign arb.sel     = sel_q;
    assign arb.busy    = busy_q;
    assign arb.timeout = tout_q;

endmodule

// File: tb/tb_rr_arb_3t1.sv
// Directed bench for rr_arb_3t1 built with MAX_HOLD=4.
module tb_rr_arb_3t1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   armed;

    rr_arb_3t1_if bus ();

    rr_arb_3t1 #(.MAX_HOLD(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .arb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (bus.busy !== (bus.gnt != 3'b000)) begin
                errors++;
                $display("FAIL inv_busy: busy=%b gnt=%b", bus.busy, bus.gnt);
            end
            checks++;
            if ((bus.sel == 2'd3) !== (bus.gnt == 3'b000)) begin
                errors++;
                $display("FAIL inv_sel: sel=%0d gnt=%b", bus.sel, bus.gnt);
            end
            checks++;
            if (bus.timeout && bus.busy) begin
                errors++;
                $display("FAIL inv_tout: timeout=1 while busy=1");
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = 3'b111;
        bus.done = 1'b0;
        tick();
        tick();
        armed = 1'b1;
        checks++;
        if (bus.gnt !== 3'b000) begin
            errors++; $display("FAIL rst_gnt: got %b want 000", bus.gnt);
        end
        checks++;
        if (bus.sel !== 2'd3) begin
            errors++; $display("FAIL rst_sel: got %0d want 3", bus.sel);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.timeout !== 1'b0) begin
            errors++; $display("FAIL rst_tout: got %b want 0", bus.timeout);
        end
        bus.req = 3'b000;
        rst_n   = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 3'b010;
        tick();
        checks++;
        if (bus.gnt !== 3'b010 || bus.sel !== 2'd1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt: gnt=%b sel=%0d busy=%b want 010/1/1",
                     bus.gnt, bus.sel, bus.busy);
        end
        bus.done = 1'b1;
        bus.req  = 3'b000;
        tick();
        bus.done = 1'b0;
        checks++;
        if (bus.gnt !== 3'b000 || bus.sel !== 2'd3 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_rel: gnt=%b sel=%0d busy=%b want 000/3/0",
                     bus.gnt, bus.sel, bus.busy);
        end
        tick();
        tick();
        checks++;
        if (bus.gnt !== 3'b000 || bus.sel !== 2'd3) begin
            errors++;
            $display("FAIL single_idle: gnt=%b sel=%0d want 000/3",
                     bus.gnt, bus.sel);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] eg [7] = '{3'b001, 3'b000, 3'b010, 3'b000,
                               3'b100, 3'b000, 3'b001};
        logic [1:0] es [7] = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.req = 3'b111;
        tick();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus.gnt !== eg[i] || bus.sel !== es[i]) begin
                errors++;
                $display("FAIL fair_%0d: gnt=%b sel=%0d want %b/%0d",
                         i, bus.gnt, bus.sel, eg[i], es[i]);
            end
            bus.done = (eg[i] != 3'b000);
            tick();
        end
        bus.done = 1'b0;
        bus.req  = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.gnt !== 3'b001 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL tout_hold_%0d: gnt=%b timeout=%b want 001/0",
                         i, bus.gnt, bus.timeout);
            end
        end
        tick();
        checks++;
        if (bus.gnt !== 3'b000 || bus.sel !== 2'd3 || bus.timeout !== 1'b1) begin
            errors++;
            $display("FAIL tout_pulse: gnt=%b sel=%0d timeout=%b want 000/3/1",
                     bus.gnt, bus.sel, bus.timeout);
        end
        tick();
        checks++;
        if (bus.gnt !== 3'b001 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL tout_regrant: gnt=%b timeout=%b want 001/0",
                     bus.gnt, bus.timeout);
        end
        bus.req = 3'b000;
        tick();
        checks++;
        if (bus.gnt !== 3'b000 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL tout_drop: gnt=%b timeout=%b want 000/0",
                     bus.gnt, bus.timeout);
        end
        tick();
    endtask

    task automatic test_done_at_limit();
        do_reset();
        bus.req = 3'b001;
        for (int i = 0; i < 4; i++) tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        checks++;
        if (bus.gnt !== 3'b000 || bus.sel !== 2'd3 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL lim_done: gnt=%b sel=%0d timeout=%b want 000/3/0",
                     bus.gnt, bus.sel, bus.timeout);
        end
        tick();
        checks++;
        if (bus.gnt !== 3'b001 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL lim_regrant: gnt=%b timeout=%b want 001/0",
                     bus.gnt, bus.timeout);
        end
        bus.req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req = 3'b100;
        tick();
        checks++;
        if (bus.gnt !== 3'b100 || bus.sel !== 2'd2) begin
            errors++;
            $display("FAIL mid_pre: gnt=%b sel=%0d want 100/2", bus.gnt, bus.sel);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.gnt !== 3'b000 || bus.sel !== 2'd3 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: gnt=%b sel=%0d busy=%b want 000/3/0",
                     bus.gnt, bus.sel, bus.busy);
        end
        rst_n   = 1'b1;
        bus.req = 3'b101;
        tick();
        checks++;
        if (bus.gnt !== 3'b001 || bus.sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_post: gnt=%b sel=%0d want 001/0", bus.gnt, bus.sel);
        end
        bus.req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 3'b110;
        tick();
        checks++;
        if (bus.gnt !== 3'b010) begin
            errors++; $display("FAIL b2b_first: gnt=%b want 010", bus.gnt);
        end
        bus.req = 3'b100;
        tick();
        checks++;
        if (bus.gnt !== 3'b000 || bus.sel !== 2'd3) begin
            errors++;
            $display("FAIL b2b_gap: gnt=%b sel=%0d want 000/3", bus.gnt, bus.sel);
        end
        tick();
        checks++;
        if (bus.gnt !== 3'b100 || bus.sel !== 2'd2) begin
            errors++;
            $display("FAIL b2b_second: gnt=%b sel=%0d want 100/2",
                     bus.gnt, bus.sel);
        end
        bus.req = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        armed    = 1'b0;
        rst_n    = 1'b0;
        bus.req  = 3'b000;
        bus.done = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_done_at_limit();
        test_mid_reset();
        test_back_to_back();
        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
